// File: rtl/csi_fifo_pkg.sv
`default_nettype none
// ============================================================================
// csi_fifo_pkg : shared sizing helper and default geometry for stream FIFOs
// Revision    : 1.0
// ============================================================================
package csi_fifo_pkg;

  localparam int c_default_depth        = 8;
  localparam int c_default_width        = 33;
  localparam int c_default_afull_margin = 3;

  // Occupancy needs one bit beyond the pointer so that "full" is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_stream_fifo.sv
`default_nettype none
// ============================================================================
// bram_stream_fifo : AXI-Stream register FIFO with almost-full and sticky overflow
//                    Optional tlast sideband: define BRAM_STREAM_FIFO_TLAST_EN
// Revision         : 1.0
// ============================================================================
module bram_stream_fifo
  import csi_fifo_pkg::*;
#(
  parameter int DEPTH        = c_default_depth,
  parameter int WIDTH        = c_default_width,
  parameter int AFULL_MARGIN = c_default_afull_margin
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           flush_in,
  input  logic                           s_axis_tvalid,
  input  logic [WIDTH-1:0]               s_axis_tdata,
`ifdef BRAM_STREAM_FIFO_TLAST_EN
  input  logic                           s_axis_tlast,
  output logic                           m_axis_tlast,
`endif
  output logic                           s_axis_tready,
  output logic                           m_axis_tvalid,
  output logic [WIDTH-1:0]               m_axis_tdata,
  input  logic                           m_axis_tready,
  output logic [count_width(DEPTH)-1:0]  count_out,
  output logic                           afull_out,
  output logic                           overflow_out
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = count_width(DEPTH);
`ifdef BRAM_STREAM_FIFO_TLAST_EN
  localparam int c_ent_w = WIDTH + 1;
`else
  localparam int c_ent_w = WIDTH;
`endif
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_afull_th = c_cnt_w'(DEPTH - AFULL_MARGIN);

  logic [c_ent_w-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_overflow;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_wr_en;
  logic [c_ent_w-1:0] w_wr_entry;
  logic [c_ent_w-1:0] w_head;

  assign w_full  = (r_count == c_full_cnt);
  assign w_empty = (r_count == '0);
  assign w_push  = s_axis_tvalid & ~w_full;
  assign w_pop   = ~w_empty & m_axis_tready;
  assign w_wr_en = w_push & ~flush_in & rst_n_in;

`ifdef BRAM_STREAM_FIFO_TLAST_EN
  assign w_wr_entry = {s_axis_tlast, s_axis_tdata};
`else
  assign w_wr_entry = s_axis_tdata;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush_in) begin
      // Flush empties the queue but keeps the sticky overflow history.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      if (s_axis_tvalid && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  // Head is forced to zero when empty so the unreset array never shows through.
  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

  assign s_axis_tready = ~w_full;
  assign m_axis_tvalid = ~w_empty;
  assign m_axis_tdata  = w_head[WIDTH-1:0];
`ifdef BRAM_STREAM_FIFO_TLAST_EN
  assign m_axis_tlast  = w_head[WIDTH];
`endif
  assign count_out     = r_count;
  assign afull_out     = (r_count >= c_afull_th);
  assign overflow_out  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_fifo.sv
`default_nettype none
// ============================================================================
// tb_bram_stream_fifo : directed self-checking bench for bram_stream_fifo
// Revision            : 1.0
// ============================================================================
module tb_bram_stream_fifo;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        flush_in;
  logic        s_axis_tvalid;
  logic [32:0] s_axis_tdata;
  logic        s_axis_tready;
  logic        m_axis_tvalid;
  logic [32:0] m_axis_tdata;
  logic        m_axis_tready;
  logic [3:0]  count_out;
  logic        afull_out;
  logic        overflow_out;
`ifdef BRAM_STREAM_FIFO_TLAST_EN
  logic        s_axis_tlast;
  logic        m_axis_tlast;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  bram_stream_fifo #(.DEPTH(8), .WIDTH(33), .AFULL_MARGIN(3)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .flush_in      (flush_in),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
`ifdef BRAM_STREAM_FIFO_TLAST_EN
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tlast  (m_axis_tlast),
`endif
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tready (m_axis_tready),
    .count_out     (count_out),
    .afull_out     (afull_out),
    .overflow_out  (overflow_out)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    flush_in      = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
`ifdef BRAM_STREAM_FIFO_TLAST_EN
    s_axis_tlast  = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n_in = 1'b0;
    tick();
    checks++;
    if (count_out !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_out); end
    checks++;
    if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_mvalid got=%b exp=0", m_axis_tvalid); end
    checks++;
    if (m_axis_tdata !== 33'd0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
    checks++;
    if (afull_out !== 1'b0 || overflow_out !== 1'b0) begin
      failures++; $display("FAIL reset_flags got afull=%b ovf=%b exp 0 0", afull_out, overflow_out);
    end
    rst_n_in = 1'b1;
    tick();
    checks++;
    if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL reset_sready got=%b exp=1", s_axis_tready); end
  endtask

  // Fill to full with the consumer stalled, force one write while full, then drain.
  task automatic test_fill_afull();
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 33'(i);
      checks++;
      if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL fill_sready i=%0d got=%b exp=1", i, s_axis_tready); end
      tick();
      checks++;
      if (count_out !== 4'(i)) begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count_out, i); end
      checks++;
      if (afull_out !== (i >= 5)) begin failures++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, afull_out, (i >= 5)); end
      checks++;
      if (m_axis_tdata !== 33'd1) begin failures++; $display("FAIL fill_head_stable i=%0d got=%h exp=1", i, m_axis_tdata); end
    end
    checks++;
    if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL full_sready got=%b exp=0", s_axis_tready); end
    checks++;
    if (overflow_out !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow_out); end
    s_axis_tdata = 33'd9;
    tick();
    s_axis_tvalid = 1'b0;
    checks++;
    if (overflow_out !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow_out); end
    checks++;
    if (count_out !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count_out); end
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 33'(i)) begin
        failures++; $display("FAIL drain_data i=%0d got v=%b d=%h exp v=1 d=%h", i, m_axis_tvalid, m_axis_tdata, 33'(i));
      end
      tick();
      checks++;
      if (count_out !== 4'(8 - i)) begin failures++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, count_out, 8 - i); end
      checks++;
      if (afull_out !== ((8 - i) >= 5)) begin failures++; $display("FAIL drain_afull i=%0d got=%b exp=%b", i, afull_out, ((8 - i) >= 5)); end
    end
    checks++;
    if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", m_axis_tvalid); end
    m_axis_tready = 1'b0;
  endtask

  task automatic test_throughput();
    do_reset();
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 33'd1;
    tick();
    for (int k = 2; k <= 20; k++) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 33'(k - 1) || count_out !== 4'd1) begin
        failures++;
        $display("FAIL thru k=%0d got v=%b d=%h c=%0d exp v=1 d=%h c=1", k, m_axis_tvalid, m_axis_tdata, count_out, 33'(k - 1));
      end
      s_axis_tdata = 33'(k);
      tick();
    end
    s_axis_tvalid = 1'b0;
    checks++;
    if (m_axis_tdata !== 33'd20) begin failures++; $display("FAIL thru_last got=%h exp=14", m_axis_tdata); end
    tick();
    checks++;
    if (count_out !== 4'd0 || m_axis_tvalid !== 1'b0) begin
      failures++; $display("FAIL thru_end got c=%0d v=%b exp c=0 v=0", count_out, m_axis_tvalid);
    end
    m_axis_tready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [32:0] q[$];
    logic        prev_stall;
    logic [32:0] prev_data;
    logic        push;
    logic        pop;
    do_reset();
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int n = 0; n < 1000; n++) begin
      s_axis_tvalid = ($urandom_range(0, 9) < 6);
      s_axis_tdata  = {1'($urandom), 32'($urandom)};
      m_axis_tready = ($urandom_range(0, 1) == 1);
      checks++;
      if (count_out !== 4'(q.size())) begin failures++; $display("FAIL bp_count n=%0d got=%0d exp=%0d", n, count_out, q.size()); end
      checks++;
      if (s_axis_tready !== (q.size() != 8) || m_axis_tvalid !== (q.size() != 0)) begin
        failures++; $display("FAIL bp_hs n=%0d got sr=%b mv=%b size=%0d", n, s_axis_tready, m_axis_tvalid, q.size());
      end
      if (q.size() != 0) begin
        checks++;
        if (m_axis_tdata !== q[0]) begin failures++; $display("FAIL bp_data n=%0d got=%h exp=%h", n, m_axis_tdata, q[0]); end
      end
      if (prev_stall) begin
        checks++;
        if (m_axis_tdata !== prev_data || m_axis_tvalid !== 1'b1) begin
          failures++; $display("FAIL bp_stall n=%0d got=%h exp=%h", n, m_axis_tdata, prev_data);
        end
      end
      push = s_axis_tvalid && (q.size() != 8);
      pop  = m_axis_tready && (q.size() != 0);
      prev_stall = (q.size() != 0) && !m_axis_tready;
      prev_data  = (q.size() != 0) ? q[0] : '0;
      tick();
      if (pop) void'(q.pop_front());
      if (push) q.push_back(s_axis_tdata);
    end
    idle_inputs();
  endtask

  task automatic test_flush_reset();
    do_reset();
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_axis_tdata = 33'(16 + i);
      tick();
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    m_axis_tready = 1'b0;
    checks++;
    if (count_out !== 4'd5 || overflow_out !== 1'b1 || m_axis_tdata !== 33'd19) begin
      failures++; $display("FAIL pre_flush got c=%0d ovf=%b d=%h exp c=5 ovf=1 d=13", count_out, overflow_out, m_axis_tdata);
    end
    flush_in      = 1'b1;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    s_axis_tdata  = 33'h1_dead_beef;
    tick();
    idle_inputs();
    checks++;
    if (count_out !== 4'd0 || m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
      failures++; $display("FAIL flush got c=%0d mv=%b sr=%b exp c=0 mv=0 sr=1", count_out, m_axis_tvalid, s_axis_tready);
    end
    checks++;
    if (overflow_out !== 1'b1) begin failures++; $display("FAIL flush_ovf got=%b exp=1", overflow_out); end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 33'h55;
    tick();
    s_axis_tvalid = 1'b0;
    checks++;
    if (count_out !== 4'd1 || m_axis_tdata !== 33'h55) begin
      failures++; $display("FAIL post_flush got c=%0d d=%h exp c=1 d=55", count_out, m_axis_tdata);
    end
    rst_n_in      = 1'b0;
    flush_in      = 1'b0;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b0;
    tick();
    rst_n_in = 1'b1;
    idle_inputs();
    checks++;
    if (count_out !== 4'd0 || m_axis_tvalid !== 1'b0 || overflow_out !== 1'b0) begin
      failures++; $display("FAIL rst_mid got c=%0d mv=%b ovf=%b exp 0 0 0", count_out, m_axis_tvalid, overflow_out);
    end
  endtask

`ifdef BRAM_STREAM_FIFO_TLAST_EN
  task automatic test_tlast();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 33'(32 + i);
      s_axis_tlast  = (i == 4);
      tick();
    end
    idle_inputs();
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (m_axis_tdata !== 33'(32 + i) || m_axis_tlast !== (i == 4)) begin
        failures++; $display("FAIL tlast i=%0d got d=%h l=%b exp d=%h l=%b", i, m_axis_tdata, m_axis_tlast, 33'(32 + i), (i == 4));
      end
      tick();
    end
    checks++;
    if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL tlast_empty got=%b exp=0", m_axis_tlast); end
    m_axis_tready = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_in = 1'b0;
    idle_inputs();
    test_reset();
    test_fill_afull();
    test_throughput();
    test_backpressure();
    test_flush_reset();
`ifdef BRAM_STREAM_FIFO_TLAST_EN
    test_tlast();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
